unidade_controle_ula: RTL and testbench
=======================================

UNIDADE_CONTROLE_ULA -- requirements
Module: unidade_controle_ula

Interface
REQ-001 SHALL have parameter LARGURA, default 8, giving the operand/result width in bits.
REQ-002 SHALL have parameter OPCODE_BITS, default 3, giving the opcode width in bits.
REQ-003 SHALL have port clk, input, 1, single system clock, rising edge active.
REQ-004 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port pulso_confirma, input, 1, one-cycle confirm pulse from the button edge detector.
REQ-006 SHALL have port pulso_cancela, input, 1, one-cycle cancel pulse from a second edge detector.
REQ-007 SHALL have port chaves, input, LARGURA, switch value sampled on confirm.
REQ-008 SHALL have port resultado_ula, input, LARGURA, combinational ALU result for reg_a/reg_b/opcode.
REQ-009 SHALL have ports carry_ula and overflow_ula, input, 1 each, ALU flags.
REQ-010 SHALL have ports reg_a and reg_b, output, LARGURA each, latched operands driving the ALU.
REQ-011 SHALL have port opcode, output, OPCODE_BITS, latched operation select.
REQ-012 SHALL have port resultado, output, LARGURA, latched result; flag outputs carry and overflow, 1 each.
REQ-013 SHALL have port resultado_valido, output, 1, high while a latched result is displayed.
REQ-014 SHALL have port estado, output, 3, current FSM state code.

Function
REQ-015 SHALL implement FSM states ESPERA_A=0, ESPERA_B=1, ESPERA_OP=2, EXECUTA=3, MOSTRA=4; codes 5-7 SHALL go to ESPERA_A on the next edge.
REQ-016 ESPERA_A + pulso_confirma SHALL load reg_a<=chaves and go to ESPERA_B on the same edge.
REQ-017 ESPERA_B + pulso_confirma SHALL load reg_b<=chaves and go to ESPERA_OP.
REQ-018 ESPERA_OP + pulso_confirma SHALL load opcode<=chaves[OPCODE_BITS-1:0] and go to EXECUTA.
REQ-019 EXECUTA SHALL last exactly one cycle, unconditionally load resultado/carry/overflow from the ALU inputs, set resultado_valido=1, and go to MOSTRA.
REQ-020 Latency: confirm high at edge n in ESPERA_OP -> opcode valid after edge n; resultado and resultado_valido=1 after edge n+1.
REQ-021 MOSTRA + pulso_confirma SHALL clear resultado_valido and go to ESPERA_A; reg_a, reg_b, opcode, and resultado SHALL hold.
REQ-022 With no pulse, every waiting state SHALL hold, and all registers SHALL keep their values.
REQ-023 pulso_cancela in any state SHALL go to ESPERA_A and clear resultado_valido; operand, opcode, and result registers SHALL hold.
REQ-024 Simultaneous pulso_cancela and pulso_confirma: cancel SHALL win, and no register loads from chaves.
REQ-025 pulso_confirma in EXECUTA SHALL be ignored (no load, no extra advance); pulso_cancela in EXECUTA SHALL still take effect, and the result SHALL NOT be latched.
REQ-026 At most one state advance per clock; a confirm held high N cycles advances one state per cycle (upstream guarantees 1-cycle pulses).
REQ-027 All outputs SHALL be registered; estado SHALL reflect the current state register.

Reset
REQ-028 reset_n low SHALL immediately, without waiting for clk, force estado=ESPERA_A, reg_a=0, reg_b=0, opcode=0, resultado=0, carry=0, overflow=0, resultado_valido=0.
REQ-029 Reset asserted mid-sequence, in any state, SHALL discard the partial entry; after release, the first confirm SHALL load reg_a.
REQ-030 While reset_n is low, input pulses SHALL be ignored.

Verification
REQ-031 Full sequence: chaves=8'h3C confirm, 8'h05 confirm, 3'd0 confirm, ALU result 8'h41 -> reg_a=3C, reg_b=05, opcode=0, resultado=41, valido=1 two edges after the third confirm.
REQ-032 Cancel in ESPERA_OP after A=8'h10, B=8'h20 -> estado=0, reg_a=10, reg_b=20, valido=0; the next confirm loads reg_a.
REQ-033 Confirm and cancel in the same cycle in ESPERA_B -> estado=0, reg_b unchanged.
REQ-034 Confirm asserted in EXECUTA -> estado=4 next cycle, opcode unchanged; confirm in MOSTRA -> estado=0, valido=0, resultado holds.
REQ-035 Async reset pulse between edges in MOSTRA -> all outputs 0 and estado=0 before the next clk edge.
REQ-036 Confirm held high 3 cycles from ESPERA_A with chaves=8'hAA -> estado=3 after the third edge, reg_a=reg_b=AA, opcode=3'b010.

Source files
------------

// File: rtl/unidade_controle_ula.sv
// rtl/unidade_controle_ula.sv - operand/opcode entry FSM that latches ALU operands and result
module unidade_controle_ula #(
   parameter int LARGURA     = 8,
   parameter int OPCODE_BITS = 3
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   pulso_confirma,
   input  logic                   pulso_cancela,
   input  logic [LARGURA-1:0]     chaves,
   input  logic [LARGURA-1:0]     resultado_ula,
   input  logic                   carry_ula,
   input  logic                   overflow_ula,
   output logic [LARGURA-1:0]     reg_a,
   output logic [LARGURA-1:0]     reg_b,
   output logic [OPCODE_BITS-1:0] opcode,
   output logic [LARGURA-1:0]     resultado,
   output logic                   carry,
   output logic                   overflow,
   output logic                   resultado_valido,
   output logic [2:0]             estado
);

   typedef enum logic [2:0] {
      ESPERA_A  = 3'd0,
      ESPERA_B  = 3'd1,
      ESPERA_OP = 3'd2,
      EXECUTA   = 3'd3,
      MOSTRA    = 3'd4
   } estado_t;

   estado_t                estado_q, estado_d;
   logic [LARGURA-1:0]     reg_a_q, reg_a_d;
   logic [LARGURA-1:0]     reg_b_q, reg_b_d;
   logic [OPCODE_BITS-1:0] opcode_q, opcode_d;
   logic [LARGURA-1:0]     resultado_q, resultado_d;
   logic                   carry_q, carry_d;
   logic                   overflow_q, overflow_d;
   logic                   valido_q, valido_d;

   // Next-state and register-load decisions; cancel overrides everything and never loads from chaves
   always_comb begin
      estado_d    = estado_q;
      reg_a_d     = reg_a_q;
      reg_b_d     = reg_b_q;
      opcode_d    = opcode_q;
      resultado_d = resultado_q;
      carry_d     = carry_q;
      overflow_d  = overflow_q;
      valido_d    = valido_q;
      if (pulso_cancela) begin
         estado_d = ESPERA_A;
         valido_d = 1'b0;
      end else begin
         case (estado_q)
            ESPERA_A: begin
               if (pulso_confirma) begin
                  reg_a_d  = chaves;
                  estado_d = ESPERA_B;
               end
            end
            ESPERA_B: begin
               if (pulso_confirma) begin
                  reg_b_d  = chaves;
                  estado_d = ESPERA_OP;
               end
            end
            ESPERA_OP: begin
               if (pulso_confirma) begin
                  opcode_d = chaves[OPCODE_BITS-1:0];
                  estado_d = EXECUTA;
               end
            end
            EXECUTA: begin
               // The ALU has had a full cycle to settle on the latched operands, so capture unconditionally
               resultado_d = resultado_ula;
               carry_d     = carry_ula;
               overflow_d  = overflow_ula;
               valido_d    = 1'b1;
               estado_d    = MOSTRA;
            end
            MOSTRA: begin
               if (pulso_confirma) begin
                  valido_d = 1'b0;
                  estado_d = ESPERA_A;
               end
            end
            default: begin
               // Unused codes recover to the start of entry
               valido_d = 1'b0;
               estado_d = ESPERA_A;
            end
         endcase
      end
   end

   // State and all output registers, cleared immediately by the asynchronous reset
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         estado_q    <= ESPERA_A;
         reg_a_q     <= '0;
         reg_b_q     <= '0;
         opcode_q    <= '0;
         resultado_q <= '0;
         carry_q     <= 1'b0;
         overflow_q  <= 1'b0;
         valido_q    <= 1'b0;
      end else begin
         estado_q    <= estado_d;
         reg_a_q     <= reg_a_d;
         reg_b_q     <= reg_b_d;
         opcode_q    <= opcode_d;
         resultado_q <= resultado_d;
         carry_q     <= carry_d;
         overflow_q  <= overflow_d;
         valido_q    <= valido_d;
      end
   end

   assign estado           = estado_q;
   assign reg_a            = reg_a_q;
   assign reg_b            = reg_b_q;
   assign opcode           = opcode_q;
   assign resultado        = resultado_q;
   assign carry            = carry_q;
   assign overflow         = overflow_q;
   assign resultado_valido = valido_q;

endmodule

// File: tb/tb_unidade_controle_ula.sv
// tb/tb_unidade_controle_ula.sv - randomized and directed checks against a behavioural model
module tb_unidade_controle_ula;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       pulso_confirma = 1'b0;
   logic       pulso_cancela = 1'b0;
   logic [7:0] chaves = 8'h00;
   logic [7:0] resultado_ula = 8'h00;
   logic       carry_ula = 1'b0;
   logic       overflow_ula = 1'b0;
   logic [7:0] reg_a, reg_b, resultado;
   logic [2:0] opcode, estado;
   logic       carry, overflow, resultado_valido;

   int pass_cnt = 0;
   int total_cnt = 0;

   // Behavioural model: which entry step we are on plus the values the user has committed
   int         m_step;
   logic [7:0] m_a, m_b, m_res;
   logic [2:0] m_op;
   logic       m_c, m_v, m_valid;

   unidade_controle_ula #(.LARGURA(8), .OPCODE_BITS(3)) dut (
      .clk(clk), .reset_n(reset_n),
      .pulso_confirma(pulso_confirma), .pulso_cancela(pulso_cancela),
      .chaves(chaves), .resultado_ula(resultado_ula),
      .carry_ula(carry_ula), .overflow_ula(overflow_ula),
      .reg_a(reg_a), .reg_b(reg_b), .opcode(opcode),
      .resultado(resultado), .carry(carry), .overflow(overflow),
      .resultado_valido(resultado_valido), .estado(estado)
   );

   always #5 clk = ~clk;

   // Small ALU: returns {carry, overflow, result}
   function automatic logic [9:0] alu(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
      logic [8:0] s;
      case (op)
         3'd0: begin
            s = {1'b0, a} + {1'b0, b};
            return {s[8], (a[7] == b[7]) && (s[7] != a[7]), s[7:0]};
         end
         3'd1: begin
            s = {1'b0, a} - {1'b0, b};
            return {s[8], (a[7] != b[7]) && (s[7] != a[7]), s[7:0]};
         end
         3'd2:    return {2'b00, a & b};
         3'd3:    return {2'b00, a | b};
         3'd4:    return {2'b00, a ^ b};
         default: return {2'b00, ~a};
      endcase
   endfunction

   function automatic logic [32:0] model_pack();
      return {3'(m_step), m_a, m_b, m_op, m_res, m_c, m_v, m_valid};
   endfunction

   function automatic logic [32:0] dut_pack();
      return {estado, reg_a, reg_b, opcode, resultado, carry, overflow, resultado_valido};
   endfunction

   task automatic model_reset();
      m_step = 0; m_a = 0; m_b = 0; m_op = 0; m_res = 0; m_c = 0; m_v = 0; m_valid = 0;
   endtask

   task automatic model_edge(input logic conf, input logic canc, input logic [7:0] ch, input logic [9:0] flags_res);
      if (canc) begin
         m_step = 0;
         m_valid = 0;
      end else if (m_step == 3) begin
         {m_c, m_v, m_res} = flags_res;
         m_valid = 1;
         m_step = 4;
      end else if (conf) begin
         if (m_step == 0) m_a = ch;
         else if (m_step == 1) m_b = ch;
         else if (m_step == 2) m_op = ch[2:0];
         else m_valid = 0;
         m_step = (m_step + 1) % 5;
      end
   endtask

   // Called at a negedge: drive inputs, clock one rising edge, update the model, return at the next negedge
   task automatic tick(input logic conf, input logic canc, input logic [7:0] ch);
      logic [9:0] f;
      f = alu(m_a, m_b, m_op);
      pulso_confirma = conf;
      pulso_cancela  = canc;
      chaves         = ch;
      {carry_ula, overflow_ula, resultado_ula} = f;
      @(posedge clk);
      if (!reset_n) model_reset();
      else model_edge(conf, canc, ch, f);
      @(negedge clk);
      pulso_confirma = 1'b0;
      pulso_cancela  = 1'b0;
   endtask

   task automatic go_idle();
      tick(1'b0, 1'b1, 8'($urandom));
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      total_cnt++;
      if (dut_pack() !== 33'h0) $display("FAIL reset_state: got %h expected %h", dut_pack(), 33'h0);
      else pass_cnt++;
      reset_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_full_sequence();
      go_idle();
      tick(1'b1, 1'b0, 8'h3C);
      tick(1'b1, 1'b0, 8'h05);
      tick(1'b1, 1'b0, 8'h00);
      total_cnt++;
      if ({estado, reg_a, reg_b, opcode, resultado_valido} !== {3'd3, 8'h3C, 8'h05, 3'd0, 1'b0})
         $display("FAIL seq_after_op: got st=%0d a=%h b=%h op=%0d v=%b expected st=3 a=3c b=05 op=0 v=0",
                  estado, reg_a, reg_b, opcode, resultado_valido);
      else pass_cnt++;
      tick(1'b0, 1'b0, 8'($urandom));
      total_cnt++;
      if ({estado, resultado, carry, overflow, resultado_valido} !== {3'd4, 8'h41, 1'b0, 1'b0, 1'b1})
         $display("FAIL seq_result: got st=%0d r=%h c=%b o=%b v=%b expected st=4 r=41 c=0 o=0 v=1",
                  estado, resultado, carry, overflow, resultado_valido);
      else pass_cnt++;
      tick(1'b1, 1'b0, 8'hEE);
      total_cnt++;
      if ({estado, resultado, reg_a, resultado_valido} !== {3'd0, 8'h41, 8'h3C, 1'b0})
         $display("FAIL seq_leave_mostra: got st=%0d r=%h a=%h v=%b expected st=0 r=41 a=3c v=0",
                  estado, resultado, reg_a, resultado_valido);
      else pass_cnt++;
   endtask

   task automatic test_cancel();
      go_idle();
      tick(1'b1, 1'b0, 8'h10);
      tick(1'b1, 1'b0, 8'h20);
      tick(1'b0, 1'b1, 8'h99);
      total_cnt++;
      if ({estado, reg_a, reg_b, resultado_valido} !== {3'd0, 8'h10, 8'h20, 1'b0})
         $display("FAIL cancel_in_op: got st=%0d a=%h b=%h v=%b expected st=0 a=10 b=20 v=0",
                  estado, reg_a, reg_b, resultado_valido);
      else pass_cnt++;
      tick(1'b1, 1'b0, 8'h77);
      total_cnt++;
      if ({estado, reg_a} !== {3'd1, 8'h77})
         $display("FAIL cancel_then_confirm: got st=%0d a=%h expected st=1 a=77", estado, reg_a);
      else pass_cnt++;
   endtask

   task automatic test_simultaneous();
      go_idle();
      tick(1'b1, 1'b0, 8'h11);
      tick(1'b1, 1'b1, 8'hC3);
      total_cnt++;
      if ({estado, reg_a, reg_b} !== {3'd0, 8'h11, 8'h20})
         $display("FAIL confirm_cancel_same: got st=%0d a=%h b=%h expected st=0 a=11 b=20", estado, reg_a, reg_b);
      else pass_cnt++;
   endtask

   task automatic test_execute_confirm();
      logic [9:0] f;
      go_idle();
      tick(1'b1, 1'b0, 8'h05);
      tick(1'b1, 1'b0, 8'h06);
      tick(1'b1, 1'b0, 8'h03);
      tick(1'b1, 1'b0, 8'hFF);
      total_cnt++;
      if ({estado, opcode, reg_a, reg_b, resultado_valido} !== {3'd4, 3'd3, 8'h05, 8'h06, 1'b1})
         $display("FAIL confirm_in_executa: got st=%0d op=%0d a=%h b=%h v=%b expected st=4 op=3 a=05 b=06 v=1",
                  estado, opcode, reg_a, reg_b, resultado_valido);
      else pass_cnt++;
      tick(1'b1, 1'b0, 8'h00);
      total_cnt++;
      if ({estado, resultado_valido, resultado} !== {3'd0, 1'b0, 8'h07})
         $display("FAIL confirm_in_mostra: got st=%0d v=%b r=%h expected st=0 v=0 r=07",
                  estado, resultado_valido, resultado);
      else pass_cnt++;
      // Cancel during EXECUTA must not latch the new result
      tick(1'b1, 1'b0, 8'h01);
      tick(1'b1, 1'b0, 8'h02);
      tick(1'b1, 1'b0, 8'h00);
      tick(1'b0, 1'b1, 8'h00);
      f = alu(8'h01, 8'h02, 3'd0);
      total_cnt++;
      if ({estado, resultado_valido, resultado} !== {3'd0, 1'b0, 8'h07} || f[7:0] == 8'h07)
         $display("FAIL cancel_in_executa: got st=%0d v=%b r=%h expected st=0 v=0 r=07",
                  estado, resultado_valido, resultado);
      else pass_cnt++;
   endtask

   task automatic test_held_confirm();
      go_idle();
      tick(1'b1, 1'b0, 8'hAA);
      tick(1'b1, 1'b0, 8'hAA);
      tick(1'b1, 1'b0, 8'hAA);
      total_cnt++;
      if ({estado, reg_a, reg_b, opcode} !== {3'd3, 8'hAA, 8'hAA, 3'b010})
         $display("FAIL held_confirm: got st=%0d a=%h b=%h op=%0d expected st=3 a=aa b=aa op=2",
                  estado, reg_a, reg_b, opcode);
      else pass_cnt++;
   endtask

   task automatic test_async_reset();
      go_idle();
      tick(1'b1, 1'b0, 8'hF0);
      tick(1'b1, 1'b0, 8'hF1);
      tick(1'b1, 1'b0, 8'h01);
      tick(1'b0, 1'b0, 8'h00);
      total_cnt++;
      if (estado !== 3'd4 || resultado_valido !== 1'b1)
         $display("FAIL async_setup: got st=%0d v=%b expected st=4 v=1", estado, resultado_valido);
      else pass_cnt++;
      #2 reset_n = 1'b0;
      #1;
      total_cnt++;
      if (dut_pack() !== 33'h0) $display("FAIL async_reset: got %h expected %h", dut_pack(), 33'h0);
      else pass_cnt++;
      #1 reset_n = 1'b1;
      model_reset();
      @(negedge clk);
   endtask

   task automatic test_reset_midsequence();
      go_idle();
      tick(1'b1, 1'b0, 8'h33);
      tick(1'b1, 1'b0, 8'h34);
      reset_n = 1'b0;
      tick(1'b1, 1'b0, 8'h44);
      total_cnt++;
      if (dut_pack() !== 33'h0) $display("FAIL pulse_during_reset: got %h expected %h", dut_pack(), 33'h0);
      else pass_cnt++;
      reset_n = 1'b1;
      tick(1'b1, 1'b0, 8'h55);
      total_cnt++;
      if ({estado, reg_a, reg_b} !== {3'd1, 8'h55, 8'h00})
         $display("FAIL after_reset_confirm: got st=%0d a=%h b=%h expected st=1 a=55 b=00", estado, reg_a, reg_b);
      else pass_cnt++;
   endtask

   task automatic test_random();
      int errs = 0;
      for (int i = 0; i < 400; i++) begin
         logic conf, canc;
         conf = ($urandom_range(0, 9) < 5);
         canc = ($urandom_range(0, 19) == 0);
         tick(conf, canc, 8'($urandom));
         total_cnt++;
         if (dut_pack() !== model_pack()) begin
            errs++;
            if (errs <= 10)
               $display("FAIL random_cycle_%0d: got %h expected %h", i, dut_pack(), model_pack());
         end else pass_cnt++;
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_full_sequence();
      test_cancel();
      test_simultaneous();
      test_execute_confirm();
      test_held_confirm();
      test_async_reset();
      test_reset_midsequence();
      test_random();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
